// File: rtl/int8_block_quant_ctrl.sv
// int8_block_quant_ctrl: buffers a block of INT32 words, picks a power-of-two scale, streams rounded/saturated INT8.
// Optional QUANT_SCALE_OVR_EN adds a scale override input and a saturation counter.
module int8_block_quant_ctrl #(
    parameter int BLOCK_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] out_scale,
    output logic        out_last,
    output logic        busy
`ifdef QUANT_SCALE_OVR_EN
    ,
    input  logic        scale_ovr_en,
    input  logic [4:0]  scale_ovr_sh,
    output logic [15:0] sat_cnt
`endif
);
    localparam int CNT_W = $clog2(BLOCK_LEN);
    typedef enum logic [1:0] {LOAD, SCALE, DRAIN} state_t;
    state_t state;
    logic [CNT_W-1:0] wcnt, rcnt;
    logic [32:0] maxabs, in_abs, q_abs;
    logic [31:0] mem [BLOCK_LEN];
    logic [31:0] q_word;
    logic [33:0] q_rnd;
    logic [7:0]  q_data;
    logic [4:0]  sh_reg, sh_calc, sh_sel, q_sh;
    logic        q_sat;

    function automatic logic [33:0] rnd(input logic [32:0] m, input logic [4:0] s);
        return (s == 5'd0) ? {1'b0, m} : ({1'b0, m} + (34'd1 << (s - 5'd1))) >> s;
    endfunction

    // 33-bit magnitude so that -2^31 maps to +2^31 without wrapping
    function automatic logic [32:0] absv(input logic [31:0] x);
        return x[31] ? 33'd0 - {1'b1, x} : {1'b0, x};
    endfunction

    always_comb begin
        sh_calc = 5'd31;
        for (int s = 31; s >= 0; s--)
            if (rnd(maxabs, 5'(s)) <= 34'd127) sh_calc = 5'(s);
    end

`ifdef QUANT_SCALE_OVR_EN
    assign sh_sel = scale_ovr_en ? scale_ovr_sh : sh_calc;
`else
    assign sh_sel = sh_calc;
`endif

    // The first beat is quantised in SCALE with the freshly chosen shift
    assign q_sh     = (state == SCALE) ? sh_sel : sh_reg;
    assign q_word   = mem[rcnt];
    assign q_abs    = absv(q_word);
    assign q_rnd    = rnd(q_abs, q_sh);
    assign q_sat    = q_word[31] ? (q_rnd > 34'd128) : (q_rnd > 34'd127);
    assign q_data   = q_sat ? (q_word[31] ? 8'h80 : 8'h7f)
                            : (q_word[31] ? 8'd0 - q_rnd[7:0] : q_rnd[7:0]);
    assign in_abs   = absv(in_data);
    assign in_ready = (state == LOAD) && !rst;
    assign busy     = (state != LOAD) || (wcnt != '0);

    always_ff @(posedge clk)
        if (state == LOAD && in_valid) mem[wcnt] <= in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            wcnt      <= '0;
            rcnt      <= '0;
            maxabs    <= '0;
            sh_reg    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_scale <= 32'h1;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    maxabs <= (in_abs > maxabs) ? in_abs : maxabs;
                    wcnt   <= (wcnt == CNT_W'(BLOCK_LEN - 1)) ? '0 : wcnt + 1'b1;
                    if (wcnt == CNT_W'(BLOCK_LEN - 1)) state <= SCALE;
                end
                SCALE: begin
                    sh_reg    <= sh_sel;
                    out_scale <= 32'h1 << sh_sel;
                    out_data  <= q_data;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    rcnt      <= CNT_W'(1);
                    state     <= DRAIN;
                end
                DRAIN: if (out_ready) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rcnt      <= '0;
                        maxabs    <= '0;
                        state     <= LOAD;
                    end else begin
                        out_data <= q_data;
                        out_last <= (rcnt == CNT_W'(BLOCK_LEN - 1));
                        rcnt     <= rcnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef QUANT_SCALE_OVR_EN
    logic out_sat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sat <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (state == SCALE || (state == DRAIN && out_ready && !out_last)) out_sat <= q_sat;
            if (state == DRAIN && out_valid && out_ready && out_sat && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_int8_block_quant_ctrl.sv
// tb_int8_block_quant_ctrl: table-driven bench for int8_block_quant_ctrl with BLOCK_LEN=4.
module tb_int8_block_quant_ctrl;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_data;
    logic [31:0] out_scale;
`ifdef QUANT_SCALE_OVR_EN
    logic        scale_ovr_en = 1'b0;
    logic [4:0]  scale_ovr_sh = '0;
    logic [15:0] sat_cnt;
`endif
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] din [4];
        logic [7:0]  dout [4];
        logic [31:0] scale;
    } vec_t;
    vec_t v [8];

    int8_block_quant_ctrl #(.BLOCK_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_scale(out_scale), .out_last(out_last), .busy(busy)
`ifdef QUANT_SCALE_OVR_EN
        , .scale_ovr_en(scale_ovr_en), .scale_ovr_sh(scale_ovr_sh), .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input int k);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("in_ready_load", in_ready, 1);
            check("busy_load", busy, j != 0);
            in_valid = 1'b1;
            in_data  = v[k].din[j];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("scale_out_valid", out_valid, 0);
        check("scale_in_ready", in_ready, 0);
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
    endtask

    task automatic drain(input int k, input int hold);
        int n = 0, beats = 0;
        out_ready = (hold == 0);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", out_valid, 1);
        for (int h = 0; h < hold; h++) begin
            check("hold_data", out_data, v[k].dout[0]);
            check("hold_valid", out_valid, 1);
            check("hold_last", out_last, 0);
            check("hold_in_ready", in_ready, 0);
            in_valid = h[0];
            in_data  = 32'h7fff_ffff;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && beats < 4; c++) begin
            if (out_valid) begin
                check("beat_data", out_data, v[k].dout[beats]);
                check("beat_last", out_last, beats == 3);
                check("beat_scale", out_scale, v[k].scale);
                beats++;
            end
            @(negedge clk);
        end
        check("beat_count", beats, 4);
        check("after_out_valid", out_valid, 0);
        check("after_in_ready", in_ready, 1);
        check("scale_held", out_scale, v[k].scale);
    endtask

    initial begin
        v[0] = '{din: '{32'd100, -32'sd50, 32'd127, 32'd0},
                 dout: '{8'd100, 8'hce, 8'd127, 8'd0}, scale: 32'h1};
        v[1] = '{din: '{32'd1000, -32'sd1000, 32'd3, -32'sd3},
                 dout: '{8'd125, 8'h83, 8'd0, 8'd0}, scale: 32'h8};
        v[2] = '{din: '{32'h8000_0000, 32'd1, 32'd0, 32'd0},
                 dout: '{8'hc0, 8'd0, 8'd0, 8'd0}, scale: 32'h0200_0000};
        v[3] = '{din: '{32'd255, -32'sd255, 32'd1, -32'sd1},
                 dout: '{8'd64, 8'hc0, 8'd0, 8'd0}, scale: 32'h4};
        v[4] = '{din: '{32'd200, -32'sd2, 32'd2, 32'd3},
                 dout: '{8'd100, 8'hff, 8'd1, 8'd2}, scale: 32'h2};
        v[5] = '{din: '{-32'sd128, 32'd0, 32'd0, 32'd0},
                 dout: '{8'hc0, 8'd0, 8'd0, 8'd0}, scale: 32'h2};
        v[6] = '{din: '{32'd0, 32'd0, 32'd0, 32'd0},
                 dout: '{8'd0, 8'd0, 8'd0, 8'd0}, scale: 32'h1};
        v[7] = '{din: '{32'd1000, -32'sd1000, 32'd5, 32'd0},
                 dout: '{8'h7f, 8'h80, 8'd5, 8'd0}, scale: 32'h1};

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_scale", out_scale, 32'h1);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        for (int k = 0; k < 6; k++) begin
            send(k);
            drain(k, 0);
        end

        // backpressure: beat 0 held for 5 cycles while in_valid pulses are ignored
        send(1);
        drain(1, 5);

        // reset after two drained beats, then a clean zero block
        send(1);
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            check("pre_rst_valid", out_valid, 1);
            check("pre_rst_data", out_data, v[1].dout[b]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        #1 check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        send(6);
        drain(6, 0);

`ifdef QUANT_SCALE_OVR_EN
        check("sat_cnt_zero", sat_cnt, 0);
        scale_ovr_en = 1'b1;
        scale_ovr_sh = 5'd0;
        send(7);
        drain(7, 0);
        scale_ovr_en = 1'b0;
        check("sat_cnt_two", sat_cnt, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
